// File: rtl/sound_dac_pkg.sv
// Shared constants for the sound output back end: mix width, weights of
// the single-bit sources, and the per-side mix adder.
package common;

  localparam int MIX_W = 12;

  // Levels contributed by the single-bit sources when they are high.
  localparam logic [9:0] BEEPER_W   = 10'd640;
  localparam logic [9:0] TAPE_OUT_W = 10'd128;
  localparam logic [9:0] TAPE_IN_W  = 10'd128;

  // Per-side mix: the channel pair counts double. Worst case 1020 + 1023 + 896
  // = 2939, which always fits MIX_W bits, so a plain add is exact.
  function automatic logic [MIX_W-1:0] mix_sum(input logic [8:0] pair,
                                               input logic [9:0] ay,
                                               input logic [9:0] ext);
    return {2'b00, pair, 1'b0} + {2'b00, ay} + {2'b00, ext};
  endfunction

endpackage

// File: rtl/sound_dac_sigma_delta1.sv
// First-order sigma-delta modulator: the carry out of a 12-bit phase
// accumulator gives a bitstream whose ones density is exactly smp / 4096.
module sigma_delta1
  import common::*;
(
  input  logic             clk28,
  input  logic             rst_n,
  input  logic [MIX_W-1:0] smp,
  output logic             dac
);

  logic [MIX_W:0] acc;
  logic [MIX_W:0] sum;

  // Carry is dropped from the stored accumulator and emitted as the bit.
  always_comb begin
    sum = {1'b0, acc[MIX_W-1:0]} + {1'b0, smp};
  end

  // Accumulate every cycle; dac is the registered carry of this cycle's sum.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      dac <= 1'b0;
    end else begin
      acc <= sum;
      dac <= sum[MIX_W];
    end
  end

endmodule

// File: rtl/sound_dac.sv
// Audio back end: tape-in synchroniser, two-stage mixer, sample-rate
// divider with sample/mute latch, and one sigma-delta modulator per side.
//
// sample_stb is a bare strobe with no handshake: it is high for exactly one
// clk28 cycle, and the sample is latched on the rising edge that ends it.
module sound_dac
  import common::*;
#(
  parameter int DIV_W = 6
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic [7:0] ch_l0,
  input  logic [7:0] ch_l1,
  input  logic [7:0] ch_r0,
  input  logic [7:0] ch_r1,
  input  logic [9:0] ay_l,
  input  logic [9:0] ay_r,
  input  logic       beeper,
  input  logic       tape_out,
  input  logic       tape_in,
  input  logic       mute,
  output logic       sample_stb,
  output logic       dac_l,
  output logic       dac_r
);

  logic [1:0]       tape_meta;
  logic             tape_sync;
  logic [8:0]       pair_l, pair_r;
  logic [9:0]       ay_l_q, ay_r_q;
  logic [9:0]       ext, ext_next;
  logic [MIX_W-1:0] mix_l, mix_r;
  logic [DIV_W-1:0] div_cnt;
  logic [MIX_W-1:0] smp_l, smp_r;

  assign tape_sync = tape_meta[1];

  // Two-flop synchroniser for the asynchronous tape comparator.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) tape_meta <= 2'b00;
    else        tape_meta <= {tape_meta[0], tape_in};
  end

  // Weighted sum of the single-bit sources.
  always_comb begin
    ext_next = (beeper    ? BEEPER_W   : 10'd0)
             + (tape_out  ? TAPE_OUT_W : 10'd0)
             + (tape_sync ? TAPE_IN_W  : 10'd0);
  end

  // Stage 1: channel pair sums, single-bit sources and AY registered together.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      pair_l <= '0;
      pair_r <= '0;
      ext    <= '0;
      ay_l_q <= '0;
      ay_r_q <= '0;
    end else begin
      pair_l <= {1'b0, ch_l0} + {1'b0, ch_l1};
      pair_r <= {1'b0, ch_r0} + {1'b0, ch_r1};
      ext    <= ext_next;
      ay_l_q <= ay_l;
      ay_r_q <= ay_r;
    end
  end

  // Stage 2: full per-side mix.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      mix_l <= '0;
      mix_r <= '0;
    end else begin
      mix_l <= mix_sum(pair_l, ay_l_q, ext);
      mix_r <= mix_sum(pair_r, ay_r_q, ext);
    end
  end

  // Free-running sample divider; wraps every 2^DIV_W cycles.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else        div_cnt <= div_cnt + 1'b1;
  end

  assign sample_stb = &div_cnt;

  // Sample latch: only updates at the strobe, so mid-period input or mute
  // changes never disturb the value the modulators are integrating.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      smp_l <= '0;
      smp_r <= '0;
    end else if (sample_stb) begin
      smp_l <= mute ? '0 : mix_l;
      smp_r <= mute ? '0 : mix_r;
    end
  end

  sigma_delta1 u_sd_l (
    .clk28 (clk28),
    .rst_n (rst_n),
    .smp   (smp_l),
    .dac   (dac_l)
  );

  sigma_delta1 u_sd_r (
    .clk28 (clk28),
    .rst_n (rst_n),
    .smp   (smp_r),
    .dac   (dac_r)
  );

endmodule
